// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SLC-3 on-chip memory responder.
package slc3_mem_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] OOR_DATA_DEFAULT = 16'h0000;

   typedef enum logic {
      INIT,
      READY
   } state_t;

   // An address is valid only when every bit above the RAM index is zero,
   // so large addresses can never alias onto low RAM words.
   function automatic logic in_range(input logic [WORD_W-1:0] addr, input int addr_w);
      return (addr >> addr_w) == '0;
   endfunction

endpackage

// File: rtl/sram_responder_rom.sv
// Program image copied into RAM by the loader after every reset.
module program_rom
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] data
);

   localparam int IMG_LEN = 8;
   localparam logic [WORD_W-1:0] IMAGE [IMG_LEN] = '{
      16'h5020, 16'h1025, 16'h0BFE, 16'hC1C0,
      16'hF025, 16'h2205, 16'h7406, 16'hABCD
   };

   // Image lookup; every word past the image end reads as zero.
   // NOTE: data gets a default before the loop so no latch is inferred.
   always_comb begin
      data = '0;
      for (int i = 0; i < IMG_LEN; i++) begin
         if (addr == ADDR_W'(i)) data = IMAGE[i];
      end
   end

endmodule

// File: rtl/sram_responder.sv
// On-chip word-addressed SRAM with a ROM-fed init loader and a
// 1- or 2-cycle registered read path, answering the SLC-3 memory bus.
module sram_responder
   import slc3_mem_pkg::*;
#(
   parameter int                ADDR_W   = 10,
   parameter int                READ_LAT = 1,
   parameter logic [WORD_W-1:0] OOR_DATA = OOR_DATA_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [15:0]       ADDR,
   input  logic              OE,
   input  logic              WE,
   input  logic [15:0]       Data_to_SRAM,
   output logic [15:0]       Data_from_SRAM,
   output logic              Init_Done,
   output logic              Oor_Err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   state_t              state, next_state;
   logic [ADDR_W-1:0]   cnt;
   logic [WORD_W-1:0]   ram [DEPTH];
   logic [WORD_W-1:0]   rom_word;
   logic                cpu_in_range;
   logic [ADDR_W-1:0]   cpu_idx;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [WORD_W-1:0]   ram_wdata;
   logic                rd_fire;
   logic [WORD_W-1:0]   rd_word;
   logic                oor_hit;
   logic                pipe_valid;
   logic [WORD_W-1:0]   pipe_word;
   logic                out_valid;
   logic [WORD_W-1:0]   out_word;

   program_rom #(.ADDR_W(ADDR_W)) u_rom (
      .addr (cnt),
      .data (rom_word)
   );

   assign cpu_in_range = in_range(ADDR, ADDR_W);
   assign cpu_idx      = ADDR[ADDR_W-1:0];
   assign Init_Done    = (state == READY);

   // State register: INIT after every reset, READY once the image is loaded.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) state <= INIT;
      else       state <= next_state;
   end

   // Next state plus the single RAM write port and the read-slot selection.
   always_comb begin
      next_state = state;
      ram_we     = 1'b0;
      ram_waddr  = cnt;
      ram_wdata  = rom_word;
      rd_fire    = 1'b0;
      rd_word    = ram[cpu_idx];
      oor_hit    = 1'b0;
      unique case (state)
         INIT: begin
            ram_we = 1'b1;
            if (cnt == CNT_LAST) next_state = READY;
         end
         READY: begin
            if (!WE && cpu_in_range) begin
               ram_we    = 1'b1;
               ram_waddr = cpu_idx;
               ram_wdata = Data_to_SRAM;
            end
            if (!OE) begin
               rd_fire = 1'b1;
               if (!cpu_in_range) rd_word = OOR_DATA;
               else if (!WE)      rd_word = Data_to_SRAM;  // write-first
            end
            oor_hit = (!OE || !WE) && !cpu_in_range;
         end
         default: next_state = INIT;
      endcase
   end

   // Loader address counter, advancing only while the image is being copied.
   always_ff @(posedge Clk) begin
      if (Reset)              cnt <= '0;
      else if (state == INIT) cnt <= cnt + 1'b1;
   end

   // RAM array write port shared by the loader and the CPU.
   // NOTE: the array has no reset; the loader rewrites every word after each reset.
   always_ff @(posedge Clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
   end

   // Optional extra read stage, only used when READ_LAT is 2.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pipe_valid <= 1'b0;
         pipe_word  <= '0;
      end else begin
         pipe_valid <= rd_fire;
         if (rd_fire) pipe_word <= rd_word;
      end
   end

   assign out_valid = (READ_LAT == 2) ? pipe_valid : rd_fire;
   assign out_word  = (READ_LAT == 2) ? pipe_word  : rd_word;

   // Output data register: updates on a completed read, otherwise holds.
   always_ff @(posedge Clk) begin
      if (Reset)          Data_from_SRAM <= '0;
      else if (out_valid) Data_from_SRAM <= out_word;
   end

   // Out-of-range flag: one pulse the cycle after an offending access.
   always_ff @(posedge Clk) begin
      if (Reset) Oor_Err <= 1'b0;
      else       Oor_Err <= oor_hit;
   end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: two responders (read latency 1 and 2) share one bus;
// expected read words are queued when a read is driven and compared when due.
module tb_sram_responder;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] ADDR;
   logic        OE;
   logic        WE;
   logic [15:0] din;
   logic [15:0] dout1, dout2;
   logic        init1, init2;
   logic        oor1, oor2;

   localparam logic [15:0] ROM_IMG [8] = '{
      16'h5020, 16'h1025, 16'h0BFE, 16'hC1C0,
      16'hF025, 16'h2205, 16'h7406, 16'hABCD
   };

   sram_responder #(.ADDR_W(10), .READ_LAT(1), .OOR_DATA(16'h0000)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
      .Data_to_SRAM(din), .Data_from_SRAM(dout1), .Init_Done(init1), .Oor_Err(oor1)
   );

   sram_responder #(.ADDR_W(10), .READ_LAT(2), .OOR_DATA(16'h0000)) u_dut2 (
      .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
      .Data_to_SRAM(din), .Data_from_SRAM(dout2), .Init_Done(init2), .Oor_Err(oor2)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] word;
      int          due;
   } sb_t;

   typedef struct {
      logic [15:0] addr;
      logic        oe;
      logic        we;
      logic [15:0] d;
      logic [15:0] exp_rd;
      logic        exp_oor;
   } vec_t;

   sb_t         q1[$];
   sb_t         q2[$];
   logic [15:0] last1, last2;
   int          cyc;
   int          n_checks;
   int          n_pass;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Compare each output against the queued read due this cycle, else the held value.
   task automatic drain();
      if (q1.size() > 0 && q1[0].due == cyc) begin
         last1 = q1[0].word;
         void'(q1.pop_front());
         check("rd_lat1", dout1, last1);
      end else begin
         check("hold_lat1", dout1, last1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
         last2 = q2[0].word;
         void'(q2.pop_front());
         check("rd_lat2", dout2, last2);
      end else begin
         check("hold_lat2", dout2, last2);
      end
   endtask

   task automatic do_cycle(input logic [15:0] a, input logic oe, input logic we,
                           input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_oor);
      ADDR = a; OE = oe; WE = we; din = d;
      if (!oe) begin
         q1.push_back('{word: exp_rd, due: cyc + 1});
         q2.push_back('{word: exp_rd, due: cyc + 2});
      end
      @(posedge Clk); @(negedge Clk);
      cyc++;
      OE = 1'b1; WE = 1'b1;
      drain();
      check("oor_lat1", 16'(oor1), 16'(exp_oor));
      check("oor_lat2", 16'(oor2), 16'(exp_oor));
   endtask

   task automatic do_reset();
      Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = '0; din = '0;
      @(posedge Clk); @(negedge Clk);
      Reset = 1'b0;
      q1.delete(); q2.delete();
      last1 = '0; last2 = '0;
      check("rst_dout1", dout1, 16'h0000);
      check("rst_dout2", dout2, 16'h0000);
      check("rst_init", 16'({init1, init2}), 16'h0000);
      check("rst_oor", 16'({oor1, oor2}), 16'h0000);
   endtask

   // Count edges until Init_Done; optionally poke CPU writes mid-load.
   task automatic wait_init(input bit poke);
      int  n;
      bit  bad_d, bad_o;
      n = 0; bad_d = 1'b0; bad_o = 1'b0;
      do begin
         if (poke && n == 600) begin
            OE = 1'b0; WE = 1'b0; ADDR = 16'h0005; din = 16'hDEAD;
         end else if (poke && n == 601) begin
            OE = 1'b0; WE = 1'b0; ADDR = 16'hFFFF; din = 16'h5555;
         end else begin
            OE = 1'b1; WE = 1'b1;
         end
         @(posedge Clk); @(negedge Clk);
         n++;
         if (dout1 !== 16'h0 || dout2 !== 16'h0) bad_d = 1'b1;
         if (oor1 !== 1'b0 || oor2 !== 1'b0) bad_o = 1'b1;
      end while (init1 !== 1'b1 && n < 1100);
      OE = 1'b1; WE = 1'b1;
      check("init_cycles", 16'(n), 16'd1024);
      check("init_done_lat2", 16'(init2), 16'h0001);
      check("init_dout_zero", 16'(bad_d), 16'h0000);
      check("init_no_oor", 16'(bad_o), 16'h0000);
   endtask

   initial begin
      vec_t vecs[20];
      n_checks = 0; n_pass = 0; cyc = 0;
      last1 = '0; last2 = '0;
      Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = '0; din = '0;

      //           addr      oe    we    data      exp_rd      exp_oor
      vecs[0]  = '{16'h0000, 1'b0, 1'b1, 16'h0000, ROM_IMG[0], 1'b0};
      vecs[1]  = '{16'h0001, 1'b0, 1'b1, 16'h0000, ROM_IMG[1], 1'b0};
      vecs[2]  = '{16'h0002, 1'b0, 1'b1, 16'h0000, ROM_IMG[2], 1'b0};
      vecs[3]  = '{16'h0003, 1'b0, 1'b1, 16'h0000, ROM_IMG[3], 1'b0};
      vecs[4]  = '{16'h0042, 1'b1, 1'b0, 16'hBEEF, 16'h0000,   1'b0};
      vecs[5]  = '{16'h0042, 1'b0, 1'b1, 16'h0000, 16'hBEEF,   1'b0};
      vecs[6]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000,   1'b0};
      vecs[7]  = '{16'h0010, 1'b0, 1'b0, 16'h1234, 16'h1234,   1'b0};
      vecs[8]  = '{16'h0010, 1'b0, 1'b1, 16'h0000, 16'h1234,   1'b0};
      vecs[9]  = '{16'h0400, 1'b0, 1'b1, 16'h0000, 16'h0000,   1'b1};
      vecs[10] = '{16'hFFFF, 1'b1, 1'b0, 16'h5555, 16'h0000,   1'b1};
      vecs[11] = '{16'h0000, 1'b0, 1'b1, 16'h0000, ROM_IMG[0], 1'b0};
      vecs[12] = '{16'h03FF, 1'b0, 1'b1, 16'h0000, 16'h0000,   1'b0};
      vecs[13] = '{16'h8010, 1'b0, 1'b0, 16'h7777, 16'h0000,   1'b1};
      vecs[14] = '{16'h0010, 1'b0, 1'b1, 16'h0000, 16'h1234,   1'b0};
      vecs[15] = '{16'h0100, 1'b1, 1'b0, 16'hAAAA, 16'h0000,   1'b0};
      vecs[16] = '{16'h0100, 1'b1, 1'b0, 16'hBBBB, 16'h0000,   1'b0};
      vecs[17] = '{16'h0100, 1'b0, 1'b1, 16'h0000, 16'hBBBB,   1'b0};
      vecs[18] = '{16'h0005, 1'b0, 1'b1, 16'h0000, ROM_IMG[5], 1'b0};
      vecs[19] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000,   1'b0};

      // Load after power-up, with CPU writes attempted during INIT.
      do_reset();
      wait_init(1'b1);

      // Table-driven READY traffic.
      for (int i = 0; i < 20; i++) begin
         do_cycle(vecs[i].addr, vecs[i].oe, vecs[i].we, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_oor);
      end

      // Back-to-back reads 1..4, then hold with OE high.
      for (int i = 1; i <= 4; i++) begin
         do_cycle(16'(i), 1'b0, 1'b1, 16'h0000, ROM_IMG[i], 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         do_cycle(16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
      end

      // Reset with a latency-2 read still in flight: it must be discarded.
      do_cycle(16'h0002, 1'b0, 1'b1, 16'h0000, ROM_IMG[2], 1'b0);
      do_reset();

      // Reset again midway through INIT; the full load must restart.
      for (int i = 0; i < 500; i++) begin
         @(posedge Clk); @(negedge Clk);
      end
      do_reset();
      wait_init(1'b1);

      // Image is reloaded: CPU data from before the reset is gone.
      do_cycle(16'h0042, 1'b0, 1'b1, 16'h0000, 16'h0000,   1'b0);
      do_cycle(16'h0005, 1'b0, 1'b1, 16'h0000, ROM_IMG[5], 1'b0);
      do_cycle(16'h0100, 1'b0, 1'b1, 16'h0000, 16'h0000,   1'b0);
      do_cycle(16'h0007, 1'b0, 1'b1, 16'h0000, ROM_IMG[7], 1'b0);
      do_cycle(16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000,   1'b0);
      do_cycle(16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000,   1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
